// File: rtl/stream_to_onchip_writer.sv
// stream_to_onchip_writer
// Packs an 8-bit Avalon-ST pixel stream into 32-bit little-endian words and
// writes them through an Avalon-MM write-only master into on-chip RAM.
// Capture is armed per frame by a start pulse. The writer reports busy, a done
// pulse, a sticky overflow flag and the number of words written.
// Optional build macro STREAM_WR_DROP_CNT_EN adds a 16-bit saturating
// drop_count output. It counts beats discarded while busy.
module stream_to_onchip_writer #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 15000,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    output logic              m_write,
    output logic              m_chipselect,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
`ifdef STREAM_WR_DROP_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SOP = 3'd1;
    localparam logic [2:0] S_PACK     = 3'd2;
    localparam logic [2:0] S_FLUSH    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // One extra bit so that the "full" address BASE+DEPTH is representable.
    localparam logic [ADDR_W:0] ADDR_BASE  = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(BASE + DEPTH);

    logic [2:0]      r_state;
    logic [ADDR_W:0] r_addr;
    logic [ADDR_W:0] r_count;
    logic [31:0]     r_pack;
    logic [1:0]      r_k;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic            r_write;
    logic            r_overflow;
    logic            r_live;

    logic [2:0]      w_state_next;
    logic [ADDR_W:0] w_addr_next;
    logic [ADDR_W:0] w_count_next;
    logic [31:0]     w_pack_next;
    logic [1:0]      w_k_next;
    logic [31:0]     w_wdata_next;
    logic [3:0]      w_be_next;
    logic            w_write_next;
    logic            w_ovf_next;

    logic            w_wr_done;
    logic            w_stall;
    logic            w_ready;
    logic            w_accept;
    logic            w_store;
    logic [ADDR_W:0] w_addr_eff;
    logic            w_full;
    logic [31:0]     w_merged;

    // Byte enables covering lanes 0..k.
    function automatic logic [3:0] be_upto(input logic [1:0] k);
        case (k)
            2'd0:    be_upto = 4'b0001;
            2'd1:    be_upto = 4'b0011;
            2'd2:    be_upto = 4'b0111;
            default: be_upto = 4'b1111;
        endcase
    endfunction

    assign w_wr_done = r_write & ~m_waitrequest;
    assign w_stall   = r_write & m_waitrequest;

    // The address as it will be once any write completing this cycle retires.
    // A beat accepted now is judged against this, so the full test never lags.
    assign w_addr_eff = r_addr + {{ADDR_W{1'b0}}, w_wr_done};
    assign w_full     = (w_addr_eff == ADDR_LIMIT);

    // Sink readiness per state; held low in IDLE until the first clock after reset.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:     w_ready = r_live;
            S_WAIT_SOP: w_ready = 1'b1;
            S_PACK:     w_ready = ~w_stall;
            default:    w_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid & w_ready;

    // Beats that carry frame data: the opening sop beat, or any non-sop beat in PACK.
    assign w_store = w_accept & (((r_state == S_WAIT_SOP) & in_sop) |
                                 ((r_state == S_PACK) & ~in_sop));

    // Current pack buffer with the incoming pixel dropped into lane r_k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[gi*8 +: 8] = (r_k == 2'(gi)) ? in_data : r_pack[gi*8 +: 8];
        end
    endgenerate

    // Next-state, packing and write-issue logic.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = w_addr_eff;
        w_count_next = r_count + {{ADDR_W{1'b0}}, w_wr_done};
        w_pack_next  = r_pack;
        w_k_next     = r_k;
        w_wdata_next = r_wdata;
        w_be_next    = r_be;
        w_write_next = w_stall;
        w_ovf_next   = r_overflow;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WAIT_SOP;
                    w_addr_next  = ADDR_BASE;
                    w_count_next = '0;
                    w_ovf_next   = 1'b0;
                    w_pack_next  = '0;
                    w_k_next     = 2'd0;
                end
            end
            S_WAIT_SOP: begin
                if (w_accept && in_sop) begin
                    w_state_next = S_PACK;
                end
            end
            S_PACK: begin
                // A new sop mid-frame ends this frame. The bytes already packed
                // go out as a partial word, and the sop beat itself is discarded.
                if (w_accept && in_sop) begin
                    if (r_k != 2'd0) begin
                        w_wdata_next = r_pack;
                        w_be_next    = be_upto(r_k - 2'd1);
                        w_write_next = 1'b1;
                    end
                    w_pack_next  = '0;
                    w_k_next     = 2'd0;
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!w_stall) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_store) begin
            if (r_overflow || w_full) begin
                // The RAM window is exhausted. Discard pixels until eop.
                w_ovf_next = 1'b1;
            end else if ((r_k == 2'd3) || in_eop) begin
                w_wdata_next = w_merged;
                w_be_next    = be_upto(r_k);
                w_write_next = 1'b1;
                w_pack_next  = '0;
                w_k_next     = 2'd0;
            end else begin
                w_pack_next  = w_merged;
                w_k_next     = r_k + 2'd1;
            end
            if (in_eop) begin
                w_state_next = S_FLUSH;
            end
        end
    end

    // State and datapath registers; reset drops m_write immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= ADDR_BASE;
            r_count    <= '0;
            r_pack     <= '0;
            r_k        <= 2'd0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_write    <= 1'b0;
            r_overflow <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_count    <= w_count_next;
            r_pack     <= w_pack_next;
            r_k        <= w_k_next;
            r_wdata    <= w_wdata_next;
            r_be       <= w_be_next;
            r_write    <= w_write_next;
            r_overflow <= w_ovf_next;
            r_live     <= 1'b1;
        end
    end

    assign in_ready     = w_ready;
    assign m_address    = r_addr[ADDR_W-1:0];
    assign m_writedata  = r_wdata;
    assign m_byteenable = r_be;
    assign m_write      = r_write;
    assign m_chipselect = r_write;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign overflow     = r_overflow;
    assign word_count   = r_count;

`ifdef STREAM_WR_DROP_CNT_EN
    logic [15:0] r_drop_count;
    logic        w_drop;

    assign w_drop = w_accept & (((r_state == S_WAIT_SOP) & ~in_sop) |
                                ((r_state == S_PACK) & (in_sop | r_overflow | w_full)));

    // Saturating count of beats discarded during a capture, cleared by start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: doc/stream_to_onchip_writer.md
Name: stream_to_onchip_writer

Overview:
- Upstream feeder for the 32-bit single-port on-chip RAM (15000 words, 14-bit word address, 4-bit byteenable).
- Accepts an 8-bit Avalon-ST pixel stream from the camera pipeline and packs 4 pixels per word, little-endian (first pixel in byte 0).
- Writes each packed word into the RAM through an Avalon-MM write-only master, so the Nios software can read one frame, or one region of interest, from the RAM.
- Armed per frame by a start pulse; reports completion, word count and overflow.

Parameters:
- ADDR_W, 14, width of the word address.
- DEPTH, 15000, number of writable words; the write address range is 0..DEPTH-1.
- BASE, 0, first word address written after start.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms capture of the next frame
- in_data  in  8  pixel
- in_valid  in  1  pixel valid
- in_sop  in  1  start of frame, qualified by in_valid
- in_eop  in  1  end of frame, qualified by in_valid
- in_ready  out  1  sink ready
- m_address  out  ADDR_W  word address
- m_writedata  out  32  packed pixels
- m_byteenable  out  4  valid bytes
- m_write  out  1  write request
- m_chipselect  out  1  equals m_write
- m_waitrequest  in  1  stall; tie to 0 for on-chip RAM
- busy  out  1  high from start until DONE
- done  out  1  one-cycle pulse on frame completion
- overflow  out  1  sticky; cleared by start
- word_count  out  ADDR_W+1  words written in the last or current frame

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; m_address = BASE.
- States: IDLE, WAIT_SOP, PACK, FLUSH, DONE.
- IDLE: in_ready = 1. Pixels are consumed and discarded. start goes to WAIT_SOP, clears overflow and word_count, and sets the address to BASE.
- WAIT_SOP: in_ready = 1. Beats without in_sop are discarded. A beat with in_sop goes to PACK and is byte 0 of the first word. If that beat also has in_eop, go to FLUSH.
- PACK: each accepted beat is stored at byte index k (k = 0..3, then wraps to 0).
  - On k = 3: the next cycle presents m_write = 1, byteenable 4'hF, the current address.
  - The beat with in_eop goes to FLUSH. A partial word (k < 3) is written with byteenable of the low k+1 bits set; unused bytes are 0.
- Write handshake: a write completes on a cycle with m_write & ~m_waitrequest. Then the address increments and word_count increments.
  - While m_write & m_waitrequest, all m_* outputs hold and in_ready = 0.
  - Write latency: 1 cycle from the accepting clock edge of the 4th byte to m_write high.
- FLUSH: in_ready = 0 until any pending write completes, then go to DONE.
- DONE: done pulses for one cycle, then IDLE. busy = 0 in IDLE; busy = 1 in all other states.
- Full: a write is not issued when the address equals BASE+DEPTH. Instead overflow = 1 and the word is dropped. Remaining pixels are accepted and discarded until in_eop, then DONE. The address never wraps.
- sop mid-frame (in PACK): the partial word is flushed (partial byteenable) and the frame ends (DONE). The new frame is ignored until the next start.
- start while busy is ignored.
- A reset_n assertion mid-write drops m_write in the same cycle (asynchronous) and returns to IDLE.
- in_sop and in_eop on the same beat form a 1-pixel frame: one write with byteenable 4'b0001.

Optional Feature:
- Macro: STREAM_WR_DROP_CNT_EN.
- Defined: adds output drop_count, 16 bits, saturating at 16'hFFFF. It counts beats discarded while busy (pre-sop in WAIT_SOP, post-overflow) and is cleared by start.
- Undefined: no port, no counter. All other behaviour is identical.

Test Plan:
- Full-word frame: start, then 8 beats 0x01..0x08 (sop on 0x01, eop on 0x08), waitrequest = 0.
  - Writes: addr 0 = 0x04030201 and addr 1 = 0x08070605, both byteenable F.
  - done pulses 1 cycle after the 2nd write; word_count = 2.
- Partial frame: 6 beats 0xA0..0xA5.
  - Writes: 0xA3A2A1A0 with byteenable F, then 0x0000A5A4 with byteenable 4'b0011.
- Backpressure: m_waitrequest held high 3 cycles during the 1st write.
  - m_address, m_writedata, m_byteenable and m_write stable for all 4 cycles; in_ready = 0 throughout.
  - No pixel lost; final RAM contents match the full-word frame case.
- Overflow: DEPTH = 4, BASE = 0, frame of 24 beats.
  - Exactly 4 writes (addr 0..3); overflow = 1; word_count = 4; done pulses after eop.
  - With STREAM_WR_DROP_CNT_EN, drop_count = 8.
- Pre-sop discard and reset: 3 beats without sop after start, then a 4-beat frame.
  - Exactly one write, 0 dropped-frame data.
  - Then assert reset_n low mid-write: m_write falls immediately, all outputs 0, state IDLE.
